// File: rtl/seg_pkg.sv
// Shared 7-segment definitions: blank pattern, active-high segment ROM and a
// polarity helper. Segment bit order is {g,f,e,d,c,b,a}.
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Active-high segment pattern for a BCD nibble; codes 10..15 are blank so
    // a counter briefly presenting a non-decimal value never lights garbage.
    function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
        logic [6:0] pat;
        case (bcd)
            4'd0:    pat = 7'h3F;
            4'd1:    pat = 7'h06;
            4'd2:    pat = 7'h5B;
            4'd3:    pat = 7'h4F;
            4'd4:    pat = 7'h66;
            4'd5:    pat = 7'h6D;
            4'd6:    pat = 7'h7D;
            4'd7:    pat = 7'h07;
            4'd8:    pat = 7'h7F;
            4'd9:    pat = 7'h6F;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

    // Converts an active-high segment pattern to the board's pin polarity.
    function automatic logic [6:0] seg_polarize(input logic [6:0] pat, input logic inv);
        return pat ^ {7{inv}};
    endfunction

endpackage

// File: rtl/seg_scan_display_if.sv
// Bundle between the counter chain (master) and the scanned display driver
// (slave): digit values and controls in, segment/anode pins out.
interface seg_scan_display_if #(
    parameter int DIGITS = 4
);
    logic                  en;
    logic [4*DIGITS-1:0]   digits_in;
    logic [DIGITS-1:0]     dp_in;
    logic                  lz_blank;
    logic [6:0]            seg;
    logic                  dp;
    logic [DIGITS-1:0]     an;

    modport master (
        output en, digits_in, dp_in, lz_blank,
        input  seg, dp, an
    );

    modport slave (
        input  en, digits_in, dp_in, lz_blank,
        output seg, dp, an
    );
endinterface

// File: rtl/seg_decode_rom.sv
// Combinational BCD to 7-segment decode with a force-blank input, used on the
// currently selected digit.
module seg_decode_rom
    import seg_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    // Blank request overrides the ROM value (leading-zero suppression).
    always_comb begin
        seg = seg_decode(bcd);
        if (blank) begin
            seg = SEG_BLANK;
        end
    end

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed 7-segment scanner. Digits are captured once per frame into a
// shadow so mid-frame counter carries cannot tear the readout; each digit slot
// starts with one dead cycle to avoid ghosting between anodes.
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int COMMON_ANODE = 0
) (
    input  logic              fclk,
    input  logic              reset,
    seg_scan_display_if.slave bus
);

    localparam int   PW    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int   IW    = (DIGITS > 2) ? $clog2(DIGITS) : 1;
    localparam logic INACT = (COMMON_ANODE != 0);

    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] INDEX_LAST = IW'(DIGITS - 1);

    logic [PW-1:0]     presc;
    logic [IW-1:0]     index;
    logic [3:0]        shadow [DIGITS];
    logic [DIGITS-1:0] shadow_dp;

    logic              frame_start;
    logic [DIGITS-1:0] lz_mask;
    logic [3:0]        digit_cur;
    logic              blank_lz;
    logic [6:0]        seg_ah;
    logic [DIGITS-1:0] an_ah;

    logic [6:0]        seg_nxt;
    logic              dp_nxt;
    logic [DIGITS-1:0] an_nxt;

    logic [6:0]        seg_q;
    logic              dp_q;
    logic [DIGITS-1:0] an_q;

    assign frame_start = bus.en && (index == '0) && (presc == '0);

    // Slot timer and digit index; both hold while scanning is disabled.
    always_ff @(posedge fclk) begin
        if (reset) begin
            presc <= '0;
            index <= '0;
        end else if (bus.en) begin
            if (presc == PRESC_LAST) begin
                presc <= '0;
                index <= (index == INDEX_LAST) ? '0 : index + IW'(1);
            end else begin
                presc <= presc + PW'(1);
            end
        end
    end

    // Frame-coherent capture of the digit values and decimal points.
    always_ff @(posedge fclk) begin
        if (reset) begin
            for (int i = 0; i < DIGITS; i++) begin
                shadow[i] <= 4'd0;
            end
            shadow_dp <= '0;
        end else if (frame_start) begin
            for (int i = 0; i < DIGITS; i++) begin
                shadow[i] <= bus.digits_in[4*i +: 4];
            end
            shadow_dp <= bus.dp_in;
        end
    end

    // Mark digits that are zero with only zeros above them; digit 0 is never marked.
    always_comb begin
        logic zero_run;
        lz_mask  = '0;
        zero_run = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_run   = zero_run && (shadow[k] == 4'd0);
            lz_mask[k] = zero_run;
        end
    end

    assign digit_cur = shadow[index];
    assign blank_lz  = bus.lz_blank && lz_mask[index];

    seg_decode_rom u_rom (
        .bcd   (digit_cur),
        .blank (blank_lz),
        .seg   (seg_ah)
    );

    // One-hot active-high anode for the current index.
    always_comb begin
        an_ah        = '0;
        an_ah[index] = 1'b1;
    end

    // Pin values for the next edge: dark when frozen or in the dead cycle.
    always_comb begin
        seg_nxt = {7{INACT}};
        dp_nxt  = INACT;
        an_nxt  = {DIGITS{INACT}};
        if (bus.en && (presc != '0)) begin
            seg_nxt = seg_polarize(seg_ah, INACT);
            dp_nxt  = shadow_dp[index] ^ INACT;
            an_nxt  = an_ah ^ {DIGITS{INACT}};
        end
    end

    // Registered pin drivers.
    always_ff @(posedge fclk) begin
        if (reset) begin
            seg_q <= {7{INACT}};
            dp_q  <= INACT;
            an_q  <= {DIGITS{INACT}};
        end else begin
            seg_q <= seg_nxt;
            dp_q  <= dp_nxt;
            an_q  <= an_nxt;
        end
    end

    assign bus.seg = seg_q;
    assign bus.dp  = dp_q;
    assign bus.an  = an_q;

endmodule

// File: tb/tb_seg_scan_display.sv
module tb_seg_scan_display;

    localparam int D     = 4;
    localparam int SD    = 4;
    localparam int FRAME = D * SD;

    localparam logic [6:0] REF_ROM [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00
    };

    logic            fclk;
    logic            reset;
    logic            en;
    logic [4*D-1:0]  digits_in;
    logic [D-1:0]    dp_in;
    logic            lz_blank;

    int n_pass;
    int n_total;

    // reference model: count of enabled cycles since reset plus the captured frame
    int              t;
    logic [4*D-1:0]  m_sh;
    logic [D-1:0]    m_dp;

    seg_scan_display_if #(.DIGITS(D)) bus0 ();
    seg_scan_display_if #(.DIGITS(D)) bus1 ();

    assign bus0.en        = en;
    assign bus0.digits_in = digits_in;
    assign bus0.dp_in     = dp_in;
    assign bus0.lz_blank  = lz_blank;
    assign bus1.en        = en;
    assign bus1.digits_in = digits_in;
    assign bus1.dp_in     = dp_in;
    assign bus1.lz_blank  = lz_blank;

    seg_scan_display #(.DIGITS(D), .SCAN_DIV(SD), .COMMON_ANODE(0)) dut0 (
        .fclk  (fclk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    seg_scan_display #(.DIGITS(D), .SCAN_DIV(SD), .COMMON_ANODE(1)) dut1 (
        .fclk  (fclk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    initial fclk = 1'b0;
    always #5 fclk = ~fclk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    // One clock: predict pins from the model, advance the model, compare both DUTs.
    task automatic step();
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        logic [3:0] e_an_n;
        logic [6:0] e_seg_n;
        logic       e_dp_n;
        int         k;
        logic       lzb;
        e_an  = '0;
        e_seg = '0;
        e_dp  = 1'b0;
        if (!reset && en && (t % SD) != 0) begin
            k     = (t / SD) % D;
            e_an  = 4'(1 << k);
            e_seg = REF_ROM[m_sh[4*k +: 4]];
            e_dp  = m_dp[k];
            if (lz_blank && k >= 1) begin
                lzb = 1'b1;
                for (int j = k; j < D; j++) begin
                    if (m_sh[4*j +: 4] != 4'd0) lzb = 1'b0;
                end
                if (lzb) e_seg = 7'h00;
            end
        end
        e_an_n  = e_an ^ 4'hF;
        e_seg_n = e_seg ^ 7'h7F;
        e_dp_n  = ~e_dp;
        @(posedge fclk);
        if (reset) begin
            t    = 0;
            m_sh = '0;
            m_dp = '0;
        end else if (en) begin
            if (t % FRAME == 0) begin
                m_sh = digits_in;
                m_dp = dp_in;
            end
            t++;
        end
        #1;
        check("an_ca0",  bus0.an,  e_an);
        check("seg_ca0", bus0.seg, e_seg);
        check("dp_ca0",  bus0.dp,  e_dp);
        check("an_ca1",  bus1.an,  e_an_n);
        check("seg_ca1", bus1.seg, e_seg_n);
        check("dp_ca1",  bus1.dp,  e_dp_n);
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        t         = 0;
        m_sh      = '0;
        m_dp      = '0;
        reset     = 1'b1;
        en        = 1'b0;
        digits_in = '0;
        dp_in     = '0;
        lz_blank  = 1'b0;

        // reset values, both polarities
        repeat (3) step();
        check("rst_an0",  bus0.an,  4'h0);
        check("rst_seg0", bus0.seg, 7'h00);
        check("rst_an1",  bus1.an,  4'hF);
        check("rst_seg1", bus1.seg, 7'h7F);
        check("rst_dp1",  bus1.dp,  1'b1);

        // first frame after release
        reset     = 1'b0;
        en        = 1'b1;
        digits_in = 16'h1234;
        step();
        check("first_dead_an", bus0.an, 4'h0);
        step();
        check("first_lit_an",  bus0.an,  4'b0001);
        check("first_lit_seg", bus0.seg, 7'h66);
        check("first_lit_ca",  bus1.seg, 7'h19);
        repeat (4) step();
        check("slot1_an",  bus0.an,  4'b0010);
        check("slot1_seg", bus0.seg, 7'h4F);
        repeat (2 * FRAME) step();

        // frame coherency: change inputs while index = 2
        reset = 1'b1;
        step();
        reset     = 1'b0;
        digits_in = 16'h0199;
        repeat (10) step();
        digits_in = 16'h0200;
        step();
        check("coh_inflight", bus0.seg, 7'h06);
        repeat (15) step();
        check("coh_next_an",  bus0.an,  4'b0100);
        check("coh_next_seg", bus0.seg, 7'h5B);

        // illegal code and leading-zero blank
        reset = 1'b1;
        step();
        reset     = 1'b0;
        digits_in = 16'h00A5;
        dp_in     = 4'b0100;
        lz_blank  = 1'b1;
        repeat (2) step();
        check("lz_d0", bus0.seg, 7'h6D);
        repeat (4) step();
        check("lz_d1_illegal", bus0.seg, 7'h00);
        repeat (4) step();
        check("lz_d2_seg", bus0.seg, 7'h00);
        check("lz_d2_dp",  bus0.dp,  1'b1);
        check("lz_d2_an",  bus0.an,  4'b0100);
        repeat (4) step();
        check("lz_d3", bus0.seg, 7'h00);
        lz_blank = 1'b0;
        step();
        check("nolz_d3", bus0.seg, 7'h3F);
        repeat (11) step();
        check("nolz_d2", bus0.seg, 7'h3F);
        check("nolz_dp", bus0.dp,  1'b1);

        // polarity with an 8 on digit 0
        reset = 1'b1;
        step();
        reset     = 1'b0;
        digits_in = 16'h0008;
        dp_in     = '0;
        repeat (2) step();
        check("pol_an1",  bus1.an,  4'b1110);
        check("pol_seg1", bus1.seg, 7'h00);
        check("pol_seg0", bus0.seg, 7'h7F);

        // freeze in slot 2, then resume at the held count
        repeat (8) step();
        en = 1'b0;
        step();
        check("frz_an0",  bus0.an,  4'h0);
        check("frz_seg1", bus1.seg, 7'h7F);
        repeat (3) step();
        en = 1'b1;
        step();
        check("resume_an", bus0.an, 4'b0100);

        // reset with prescaler = 2, then shadow reload
        repeat (3) step();
        reset = 1'b1;
        step();
        check("midrst_an",  bus0.an,  4'h0);
        check("midrst_an1", bus1.an,  4'hF);
        reset     = 1'b0;
        digits_in = 16'h0003;
        repeat (2) step();
        check("reload_seg", bus0.seg, 7'h4F);

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 99) == 0);
            en    = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 7) == 0) begin
                for (int n = 0; n < D; n++) begin
                    digits_in[4*n +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                end
                dp_in    = 4'($urandom_range(0, 15));
                lz_blank = 1'($urandom_range(0, 1));
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
